// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter that shares one register-file write
// port between N_REQ write-back sources. The winning write is registered into
// a one-stage output buffer that drives a one-hot write-enable vector, the
// address and the data. A saturating counter records contention cycles.
module rf_write_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int ZERO_PROTECT = 1,
  localparam int NREG        = 2 ** ADDR_W,
  localparam int PTR_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic                      rf_stall,
  output logic                      wr_valid,
  output logic [NREG-1:0]           wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [15:0]               conflict_cnt
);

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_next;
  logic [PTR_W-1:0]  grant_idx;
  logic              found;
  logic              grant_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   sel_en;
  logic              multi_valid;

  // Round-robin search starting at ptr; the first valid index wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      logic [PTR_W-1:0] idx;
      idx = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    // No grant while the bank is stalled or while reset is held.
    grant_any = found && !rf_stall && !rst;
  end

  // One-hot ready plus selection of the winner's address and data.
  always_comb begin
    req_ready = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (PTR_W'(k) == grant_idx) begin
        req_ready[k] = grant_any;
        sel_addr     = req_addr[k*ADDR_W +: ADDR_W];
        sel_data     = req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // 5-to-32 style decode of the granted address; register 0 may be masked.
  always_comb begin
    sel_en = {{(NREG-1){1'b0}}, 1'b1} << sel_addr;
    if (ZERO_PROTECT != 0 && sel_addr == '0) begin
      sel_en = '0;
    end
  end

  // Next pointer is one past the winner, wrapping at N_REQ.
  always_comb begin
    ptr_next = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Contention detect: two or more sources pending in the same cycle.
  always_comb begin
    int vcount;
    vcount = 0;
    for (int k = 0; k < N_REQ; k++) begin
      vcount = vcount + int'(req_valid[k]);
    end
    multi_valid = (vcount >= 2);
  end

  // Output buffer, pointer and counter; everything freezes during a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= '0;
      wr_valid     <= 1'b0;
      wr_en        <= '0;
      wr_addr      <= '0;
      wr_data      <= '0;
      conflict_cnt <= '0;
    end else if (!rf_stall) begin
      wr_valid <= grant_any;
      if (grant_any) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
        wr_en   <= sel_en;
        ptr     <= ptr_next;
      end else begin
        wr_en   <= '0;
      end
      if (multi_valid && conflict_cnt != 16'hFFFF) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: directed steps with a scoreboard of
// expected writes and a small round-robin reference model. Two instances are
// driven in parallel, one with register-0 protection and one without.
module tb_rf_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic            rf_stall  = 1'b0;

  logic [N-1:0]    req_ready,    req_ready_nz;
  logic            wr_valid,     wr_valid_nz;
  logic [31:0]     wr_en,        wr_en_nz;
  logic [AW-1:0]   wr_addr,      wr_addr_nz;
  logic [DW-1:0]   wr_data,      wr_data_nz;
  logic [15:0]     conflict_cnt, conflict_cnt_nz;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [31:0]   en;
    logic [31:0]   en_nz;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  int            m_ptr   = 0;
  int            m_cnt   = 0;
  logic          m_valid = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_data  = '0;
  logic [31:0]   m_en    = '0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW), .ZERO_PROTECT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .rf_stall(rf_stall),
    .wr_valid(wr_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .conflict_cnt(conflict_cnt)
  );

  rf_write_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW), .ZERO_PROTECT(0)) dut_nz (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_nz),
    .req_addr(req_addr), .req_data(req_data), .rf_stall(rf_stall),
    .wr_valid(wr_valid_nz), .wr_en(wr_en_nz), .wr_addr(wr_addr_nz), .wr_data(wr_data_nz),
    .conflict_cnt(conflict_cnt_nz)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_cnt   = 0;
    m_valid = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    m_en    = '0;
    sb.delete();
  endtask

  // Synchronous-looking reset pulse started on a falling edge.
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock of stimulus: check ready, predict the write, compare after the edge.
  task automatic cycle();
    int   g;
    int   nv;
    logic stall;
    logic [N-1:0] er;
    exp_t e;
    #1;
    g = -1;
    stall = rf_stall;
    if (!stall) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    er = (g >= 0) ? N'(1 << g) : '0;
    check("req_ready", 64'(req_ready), 64'(er));
    check("req_ready_nz", 64'(req_ready_nz), 64'(er));
    nv = $countones(req_valid);
    if (g >= 0) begin
      e.addr  = req_addr[g*AW +: AW];
      e.data  = req_data[g*DW +: DW];
      e.en    = (e.addr == 0) ? 32'h0 : (32'h1 << e.addr);
      e.en_nz = 32'h1 << e.addr;
      sb.push_back(e);
    end
    @(posedge clk);
    if (!stall) begin
      if (g >= 0) m_ptr = (g + 1) % N;
      if (nv >= 2 && m_cnt < 65535) m_cnt++;
    end
    #1;
    if (!stall && g >= 0) begin
      e = sb.pop_front();
      m_valid = 1'b1; m_addr = e.addr; m_data = e.data; m_en = e.en;
      check("wr_valid", 64'(wr_valid), 64'(1'b1));
      check("wr_addr", 64'(wr_addr), 64'(e.addr));
      check("wr_data", 64'(wr_data), 64'(e.data));
      check("wr_en", 64'(wr_en), 64'(e.en));
      check("wr_en_nz", 64'(wr_en_nz), 64'(e.en_nz));
      $display("write: requester %0d addr %0d data %h en %h", g, wr_addr, wr_data, wr_en);
    end else if (!stall) begin
      m_valid = 1'b0; m_en = '0;
      check("idle_valid", 64'(wr_valid), 64'(1'b0));
      check("idle_en", 64'(wr_en), 64'(0));
      $display("idle cycle");
    end else begin
      check("hold_valid", 64'(wr_valid), 64'(m_valid));
      check("hold_addr", 64'(wr_addr), 64'(m_addr));
      check("hold_data", 64'(wr_data), 64'(m_data));
      check("hold_en", 64'(wr_en), 64'(m_en));
      $display("stall cycle: holding addr %0d data %h", wr_addr, wr_data);
    end
    check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_wr_valid", 64'(wr_valid), 64'(0));
    check("rst_wr_en", 64'(wr_en), 64'(0));
    check("rst_wr_addr", 64'(wr_addr), 64'(0));
    check("rst_wr_data", 64'(wr_data), 64'(0));
    check("rst_cnt", 64'(conflict_cnt), 64'(0));
    req_valid = 4'b0001;
    #1;
    check("rst_ready", 64'(req_ready), 64'(0));
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // Single request
    set_req(0, 5'd3, 32'hDEAD_BEEF);
    req_valid = 4'b0001;
    cycle();
    check("single_en_const", 64'(wr_en), 64'(32'h0000_0008));
    req_valid = '0;
    cycle();

    // Round robin, all four valid for 8 cycles
    pulse_reset();
    for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), $urandom);
    req_valid = 4'b1111;
    repeat (8) cycle();
    check("rr_cnt_const", 64'(conflict_cnt), 64'(8));
    req_valid = '0;
    cycle();

    // Stall with one write in the output stage and requester 2 waiting
    set_req(0, 5'd7, 32'hA5A5_0007);
    req_valid = 4'b0001;
    cycle();
    set_req(2, 5'd9, 32'h0000_0909);
    req_valid = 4'b0100;
    rf_stall  = 1'b1;
    repeat (3) cycle();
    rf_stall = 1'b0;
    cycle();
    check("stall_release_addr", 64'(wr_addr), 64'(9));
    req_valid = '0;
    cycle();

    // Register 0 write
    set_req(1, 5'd0, 32'h0000_1234);
    req_valid = 4'b0010;
    cycle();
    check("zero_en_prot", 64'(wr_en), 64'(0));
    check("zero_en_noprot", 64'(wr_en_nz), 64'(32'h1));
    check("zero_valid", 64'(wr_valid), 64'(1));
    req_valid = '0;
    cycle();

    // Async reset mid-operation with ptr=2 and a write in flight
    pulse_reset();
    set_req(0, 5'd11, 32'h0B0B_0B0B);
    set_req(1, 5'd12, 32'h0C0C_0C0C);
    set_req(2, 5'd13, 32'h0D0D_0D0D);
    req_valid = 4'b0001;
    cycle();
    req_valid = 4'b0010;
    cycle();
    req_valid = 4'b0101;
    #2;
    rst = 1'b1;
    #1;
    check("arst_wr_valid", 64'(wr_valid), 64'(0));
    check("arst_wr_en", 64'(wr_en), 64'(0));
    check("arst_wr_addr", 64'(wr_addr), 64'(0));
    check("arst_wr_data", 64'(wr_data), 64'(0));
    check("arst_ready", 64'(req_ready), 64'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle();
    check("arst_first_grant_addr", 64'(wr_addr), 64'(11));
    req_valid = 4'b0100;
    cycle();
    req_valid = '0;
    cycle();

    // Saturation of the contention counter
    req_valid = 4'b1111;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    check("sat_cnt", 64'(conflict_cnt), 64'(16'hFFFF));
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("sat_cnt_hold", 64'(conflict_cnt), 64'(16'hFFFF));
    check("sat_cnt_nz", 64'(conflict_cnt_nz), 64'(16'hFFFF));
    req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
